timer_irq_ctrl: RTL and testbench

Memory-mapped timer and interrupt controller on the CPU peripheral bus at base 0x4000_0000. It provides the reload timer (TH/TL/TCON) and a free-running system tick counter. It raises the interrupt request that vectors the CPU to 0x4 and paces the display-scan service routine. Register reads are combinational, matching the single-cycle datapath; writes commit on the rising clock edge.

---
 rtl/periph_pkg.sv | 31 +++
 rtl/reload_counter.sv | 40 ++++
 rtl/timer_irq_ctrl.sv | 101 ++++++++++
 tb/tb_timer_irq_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/periph_pkg.sv
// Shared register map and TCON bit layout for the memory-mapped peripherals.
package periph_pkg;

  localparam logic [5:0] OFF_TH      = 6'h00;
  localparam logic [5:0] OFF_TL      = 6'h04;
  localparam logic [5:0] OFF_TCON    = 6'h08;
  localparam logic [5:0] OFF_SYSTICK = 6'h24;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_TH,
    REG_TL,
    REG_TCON,
    REG_SYSTICK
  } reg_sel_e;

  function automatic reg_sel_e decode_offset(input logic [5:0] off);
    case (off)
      OFF_TH:      return REG_TH;
      OFF_TL:      return REG_TL;
      OFF_TCON:    return REG_TCON;
      OFF_SYSTICK: return REG_SYSTICK;
      default:     return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/reload_counter.sv
// 32-bit up counter with reload on all-ones, synchronous load port and
// combinational overflow flag (high in the cycle whose edge performs the reload).
module reload_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic        load_i,
  input  logic [31:0] load_value_i,
  input  logic [31:0] reload_i,
  output logic [31:0] count_o,
  output logic        ovf_o
);

  logic [31:0] count_q, count_d;

  assign ovf_o   = en_i & (count_q == 32'hFFFF_FFFF);
  assign count_o = count_q;

  // NOTE: next-state defaults to the held value first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (ovf_o) begin
      count_d = reload_i;
    end else if (en_i) begin
      count_d = count_q + 32'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Reload timer (TH/TL/TCON) plus free-running SYSTICK on the peripheral bus;
// drives the CPU interrupt request.
module timer_irq_ctrl
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] TH_RESET  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        kernel_mode,
  output logic        irq
);

  reg_sel_e    reg_sel;
  logic        wr_th, wr_tl, wr_tcon;
  logic [31:0] th_q, th_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [31:0] tl;
  logic        tl_ovf;
  logic [31:0] systick;
  logic        systick_wrap_unused;

  always_comb begin
    reg_sel = REG_NONE;
    if (addr[31:6] == BASE_ADDR[31:6]) begin
      reg_sel = decode_offset(addr[5:0]);
    end
  end

  assign wr_th   = mem_write & (reg_sel == REG_TH);
  assign wr_tl   = mem_write & (reg_sel == REG_TL);
  assign wr_tcon = mem_write & (reg_sel == REG_TCON);

  reload_counter u_tl (
    .clk          (clk),
    .reset        (reset),
    .en_i         (tcon_q[TCON_EN]),
    .load_i       (wr_tl),
    .load_value_i (wr_data),
    .reload_i     (th_q),
    .count_o      (tl),
    .ovf_o        (tl_ovf)
  );

  reload_counter u_systick (
    .clk          (clk),
    .reset        (reset),
    .en_i         (1'b1),
    .load_i       (1'b0),
    .load_value_i (32'd0),
    .reload_i     (32'd0),
    .count_o      (systick),
    .ovf_o        (systick_wrap_unused)
  );

  assign th_d = wr_th ? wr_data : th_q;

  // An overflow sets IS even against a software clear, as long as either the
  // old or the newly written IE is set, so no interrupt is dropped.
  always_comb begin
    tcon_d = tcon_q;
    if (wr_tcon) begin
      tcon_d = wr_data[2:0];
    end
    if (tl_ovf && (tcon_q[TCON_IE] || tcon_d[TCON_IE])) begin
      tcon_d[TCON_IS] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q   <= TH_RESET;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tcon_q <= tcon_d;
    end
  end

  assign irq = tcon_q[TCON_IS] & tcon_q[TCON_IE] & ~kernel_mode;

  always_comb begin
    rd_data = '0;
    if (mem_read) begin
      case (reg_sel)
        REG_TH:      rd_data = th_q;
        REG_TL:      rd_data = tl;
        REG_TCON:    rd_data = {29'd0, tcon_q};
        REG_SYSTICK: rd_data = systick;
        default:     rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed self-checking bench for timer_irq_ctrl: reset, bring-up, acknowledge,
// collision, kernel-mode masking and address decode.
module tb_timer_irq_ctrl;

  localparam logic [31:0] A_TH      = 32'h4000_0000;
  localparam logic [31:0] A_TL      = 32'h4000_0004;
  localparam logic [31:0] A_TCON    = 32'h4000_0008;
  localparam logic [31:0] A_SYSTICK = 32'h4000_0024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        kernel_mode;
  logic        irq;

  int          n_asserts = 0;
  int          n_fail    = 0;
  int unsigned cyc       = 0;

  timer_irq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .kernel_mode (kernel_mode),
    .irq         (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; the write commits on the next rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    wr_data   = d;
    mem_write = 1'b1;
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr     = a;
    mem_read = 1'b1;
    #1;
    d        = rd_data;
    mem_read = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] s0;
    int unsigned c1, c2;

    reset = 1'b1; addr = '0; mem_read = 1'b0; mem_write = 1'b0;
    wr_data = '0; kernel_mode = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-count
    bus_write(A_TH, 32'h0000_ABCD);
    bus_write(A_TL, 32'h0000_1230);
    bus_write(A_TCON, 32'h1);
    for (int i = 0; i < 20; i++) begin
      bus_read(A_TL, v);
      if (v == 32'h1234) break;
      @(negedge clk);
    end
    check("tl_counts_to_1234", v, 32'h0000_1234);
    reset = 1'b1;
    bus_read(A_TL, v);
    check("reset_tl_immediate", v, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    @(negedge clk);
    bus_read(A_TCON, v);    check("reset_tcon", v, 32'h0);
    bus_read(A_SYSTICK, v); check("reset_systick", v, 32'h0);
    bus_read(A_TH, v);      check("reset_th", v, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus_read(A_TL, v);      check("no_count_after_reset", v, 32'h0);

    // Handler bring-up
    bus_write(A_TCON, 32'h0);
    bus_write(A_TH, 32'hFFFF_8AD0);
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TCON, 32'h3);
    bus_read(A_TL, v);      check("bringup_tl_ffff", v, 32'hFFFF_FFFF);
    check("bringup_irq_low", {31'd0, irq}, 32'h0);
    @(negedge clk);
    bus_read(A_TL, v);      check("bringup_tl_reload", v, 32'hFFFF_8AD0);
    check("bringup_irq_rise", {31'd0, irq}, 32'h1);
    c1 = cyc;

    // Acknowledge and re-arm
    bus_read(A_TCON, v);    check("ack_tcon_before", v, 32'h7);
    bus_write(A_TCON, v & 32'hFFFF_FFF9);
    check("ack_irq_drop", {31'd0, irq}, 32'h0);
    bus_read(A_TCON, v);    check("ack_tcon_after", v, 32'h1);
    bus_write(A_TCON, v | 32'h2);
    check("rearm_irq_low", {31'd0, irq}, 32'h0);
    c2 = 0;
    for (int i = 0; i < 40000; i++) begin
      if (irq) begin
        c2 = cyc;
        break;
      end
      @(negedge clk);
    end
    check("irq_period", c2 - c1, 32'd30000);
    bus_read(A_TL, v);      check("period_tl_reload", v, 32'hFFFF_8AD0);

    // TCON write colliding with the overflow edge
    bus_write(A_TCON, 32'h0);
    bus_write(A_TH, 32'hFFFF_FFF0);
    bus_write(A_TL, 32'hFFFF_FFFC);
    bus_write(A_TCON, 32'h3);
    repeat (3) @(negedge clk);
    bus_read(A_TL, v);      check("coll_tl_ffff", v, 32'hFFFF_FFFF);
    bus_write(A_TCON, 32'h1);
    bus_read(A_TCON, v);    check("coll_tcon", v, 32'h5);
    check("coll_irq_ie_off", {31'd0, irq}, 32'h0);
    bus_write(A_TCON, 32'h7);
    check("coll_irq_kept", {31'd0, irq}, 32'h1);

    // Kernel-mode masking
    kernel_mode = 1'b1;
    #1;
    check("mask_immediate", {31'd0, irq}, 32'h0);
    @(negedge clk);
    bus_write(A_TCON, 32'h1);
    bus_write(A_TCON, 32'h3);
    for (int i = 0; i < 40; i++) begin
      bus_read(A_TCON, v);
      if (v[2]) break;
      @(negedge clk);
    end
    check("mask_is_set", v, 32'h7);
    check("mask_irq_low", {31'd0, irq}, 32'h0);
    @(negedge clk);
    kernel_mode = 1'b0;
    #1;
    check("unmask_irq_high", {31'd0, irq}, 32'h1);

    // Decode
    @(negedge clk);
    bus_read(32'h4000_000C, v); check("decode_off_0c", v, 32'h0);
    bus_read(32'h4000_0040, v); check("decode_alias_40", v, 32'h0);
    addr = A_TH; mem_read = 1'b0;
    #1;
    check("no_read_strobe", rd_data, 32'h0);
    @(negedge clk);
    bus_read(A_SYSTICK, s0);
    bus_write(A_SYSTICK, 32'hDEAD_BEEF);
    bus_read(A_SYSTICK, v); check("systick_write_ignored", v, s0 + 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
